// File: rtl/sdr_pkg.sv
// Shared types and geometry helpers for the SDRAM burst master.
// The controller moves NWORDS x WORD_W blocks over a narrow BUS_W Avalon-MM port.
package sdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DRAIN,
    ST_WR,
    ST_DONE
  } sdr_state_t;

  localparam int SDR_BUS_W  = 16;
  localparam int SDR_WORD_W = 32;

  // Returns the beat count for one block, or 0 when the block is not a whole
  // number of bus beats so the instantiating module can refuse to elaborate.
  function automatic int sdr_beats(input int nwords, input int word_w, input int bus_w);
    if (bus_w <= 0 || ((nwords * word_w) % bus_w) != 0) return 0;
    return (nwords * word_w) / bus_w;
  endfunction

endpackage

// File: rtl/sdr_burst_master.sv
// Avalon-MM burst master: gathers a wide read block from BUS_W-bit beats and
// scatters a wide write block as BUS_W-bit beats, with pipelined read returns.
module sdr_burst_master
  import sdr_pkg::*;
#(
  parameter int BUS_W  = SDR_BUS_W,
  parameter int WORD_W = SDR_WORD_W,
  parameter int NWORDS = 15,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_read,
  input  logic                      start_write,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [NWORDS*WORD_W-1:0]  wr_data,
  output logic [NWORDS*WORD_W-1:0]  rd_data,
  output logic                      busy,
  output logic                      read_done,
  output logic                      write_done,
  output logic                      read_end,
  output logic                      write_end,
  output logic [ADDR_W-1:0]         avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [BUS_W-1:0]          avm_writedata,
  output logic [BUS_W/8-1:0]        avm_byteenable,
  input  logic                      avm_waitrequest,
  input  logic                      avm_readdatavalid,
  input  logic [BUS_W-1:0]          avm_readdata
);

  localparam int DATA_W = NWORDS * WORD_W;
  localparam int BEATS  = sdr_beats(NWORDS, WORD_W, BUS_W);
  localparam int STEP   = BUS_W / 8;
  localparam int CNT_W  = (BEATS > 0) ? $clog2(BEATS + 1) : 1;

  if (BEATS == 0 || BUS_W < 8 || (BUS_W & (BUS_W - 1)) != 0) begin : g_geometry_check
    $error("sdr_burst_master: BUS_W must be a power of two >= 8 dividing NWORDS*WORD_W");
  end

  sdr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] wr_latch;
  logic              is_read;
  logic              beat_accept;
  logic              start_any;

  assign start_any   = start_read | start_write;
  assign beat_accept = (avm_read | avm_write) & ~avm_waitrequest;

  // NOTE: state flops use non-blocking assignments so every process sees the
  // pre-edge value; blocking here would race with the datapath block below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next-state is defaulted to the current state before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_read)       state_nxt = ST_RD_REQ;
        else if (start_write) state_nxt = ST_WR;
      end
      ST_RD_REQ:   if (!avm_waitrequest && req_cnt == CNT_W'(BEATS - 1)) state_nxt = ST_RD_DRAIN;
      ST_RD_DRAIN: if (rcv_cnt == CNT_W'(BEATS)) state_nxt = ST_DONE;
      ST_WR:       if (!avm_waitrequest && req_cnt == CNT_W'(BEATS - 1)) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the async-reset state so a reset drops them
  // in the same instant; address and data are zeroed whenever no strobe is up.
  always_comb begin
    avm_read      = (state == ST_RD_REQ);
    avm_write     = (state == ST_WR);
    avm_address   = '0;
    avm_writedata = '0;
    if (avm_read || avm_write)
      avm_address = base_q + ADDR_W'(req_cnt) * ADDR_W'(STEP);
    if (avm_write && req_cnt < CNT_W'(BEATS))
      avm_writedata = wr_latch[int'(req_cnt) * BUS_W +: BUS_W];
  end

  assign avm_byteenable = '1;
  assign busy           = (state != ST_IDLE);

  // NOTE: the wide shadow/latch/rd_data registers are plain flops, not RAM, so
  // they take the async reset like everything else and power up as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      req_cnt    <= '0;
      rcv_cnt    <= '0;
      shadow     <= '0;
      wr_latch   <= '0;
      rd_data    <= '0;
      is_read    <= 1'b0;
      read_done  <= 1'b0;
      write_done <= 1'b0;
      read_end   <= 1'b0;
      write_end  <= 1'b0;
    end else begin
      read_done  <= 1'b0;
      write_done <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (start_any) begin
            base_q    <= base_addr & ~ADDR_W'(STEP - 1);
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            read_end  <= 1'b0;
            write_end <= 1'b0;
            is_read   <= start_read;
            if (!start_read) wr_latch <= wr_data;
          end
        end
        ST_RD_REQ, ST_WR: begin
          if (beat_accept) req_cnt <= req_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          if (is_read) begin
            rd_data   <= shadow;
            read_done <= 1'b1;
            read_end  <= 1'b1;
          end else begin
            write_done <= 1'b1;
            write_end  <= 1'b1;
          end
        end
        default: ;
      endcase

      // Returns may overlap the request phase; anything outside a read is dropped.
      if ((state == ST_RD_REQ || state == ST_RD_DRAIN) && avm_readdatavalid &&
          rcv_cnt < CNT_W'(BEATS)) begin
        shadow[int'(rcv_cnt) * BUS_W +: BUS_W] <= avm_readdata;
        rcv_cnt <= rcv_cnt + CNT_W'(1);
      end
    end
  end

endmodule
